// File: rtl/ext_irq_requester.sv
// rtl/ext_irq_requester.sv - round-robin external interrupt requester
// Collects per-source edge/level interrupts and presents one request at a time.
module ext_irq_requester #(
   parameter int IRQ_COUNT = 32
) (
   input  logic                 iCLOCK,
   input  logic                 iRESET_SYNC,
   input  logic [IRQ_COUNT-1:0] iIRQ,
   input  logic                 iCFG_VALID,
   input  logic [4:0]           iCFG_ENTRY,
   input  logic                 iCFG_ENABLE,
   input  logic                 iCFG_EDGE,
   output logic                 oEXT_ACTIVE,
   output logic [5:0]           oEXT_NUM,
   input  logic                 iEXT_ACK,
   output logic [IRQ_COUNT-1:0] oPENDING
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t               state;
   logic [IRQ_COUNT-1:0] cfg_en;
   logic [IRQ_COUNT-1:0] cfg_edge;
   logic [IRQ_COUNT-1:0] irq_prev;
   logic [IRQ_COUNT-1:0] pending;
   logic [IRQ_COUNT-1:0] pending_nxt;
   logic [IRQ_COUNT-1:0] irq_rise;
   logic [4:0]           last_grant;
   logic                 ext_active;
   logic [5:0]           ext_num;
   logic [4:0]           winner;
   logic [4:0]           idx;
   logic                 found;

   assign irq_rise    = iIRQ & ~irq_prev;
   assign oEXT_ACTIVE = ext_active;
   assign oEXT_NUM    = ext_num;
   assign oPENDING    = pending;

   // Search starts just after the last accepted source; k = 32 wraps back to it.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= IRQ_COUNT; k++) begin
         idx = last_grant + k[4:0];
         if (!found && pending[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // The source held in REQ ignores disables until it is accepted.
   always_comb begin
      pending_nxt = pending;
      for (int i = 0; i < IRQ_COUNT; i++) begin
         if (state == ST_REQ && ext_num[4:0] == i[4:0]) begin
            if (iEXT_ACK && !cfg_en[i])
               pending_nxt[i] = 1'b0;
            else if (iEXT_ACK)
               pending_nxt[i] = cfg_edge[i] ? irq_rise[i] : iIRQ[i];
            else if (cfg_en[i])
               pending_nxt[i] = cfg_edge[i] ? (pending[i] | irq_rise[i]) : iIRQ[i];
            else
               pending_nxt[i] = pending[i];
         end else if (iCFG_VALID && iCFG_ENTRY == i[4:0] && !iCFG_ENABLE) begin
            pending_nxt[i] = 1'b0;
         end else if (!cfg_en[i]) begin
            pending_nxt[i] = 1'b0;
         end else begin
            pending_nxt[i] = cfg_edge[i] ? (pending[i] | irq_rise[i]) : iIRQ[i];
         end
      end
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state      <= ST_IDLE;
         ext_active <= 1'b0;
         ext_num    <= '0;
         pending    <= '0;
         cfg_en     <= '0;
         cfg_edge   <= '0;
         irq_prev   <= '0;
         last_grant <= 5'd31;
      end else begin
         irq_prev <= iIRQ;
         pending  <= pending_nxt;
         if (iCFG_VALID) begin
            cfg_en[iCFG_ENTRY]   <= iCFG_ENABLE;
            cfg_edge[iCFG_ENTRY] <= iCFG_EDGE;
         end
         case (state)
            ST_IDLE: begin
               if (found) begin
                  ext_num    <= {1'b0, winner};
                  ext_active <= 1'b1;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (iEXT_ACK) begin
                  ext_active <= 1'b0;
                  last_grant <= ext_num[4:0];
                  state      <= ST_GAP;
               end
            end
            ST_GAP: begin
               state <= ST_IDLE;
            end
            default: begin
               ext_active <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ext_irq_requester.sv
// tb/tb_ext_irq_requester.sv - directed self-checking bench for ext_irq_requester
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ext_irq_requester;

   logic        iCLOCK;
   logic        iRESET_SYNC;
   logic [31:0] iIRQ;
   logic        iCFG_VALID;
   logic [4:0]  iCFG_ENTRY;
   logic        iCFG_ENABLE;
   logic        iCFG_EDGE;
   logic        oEXT_ACTIVE;
   logic [5:0]  oEXT_NUM;
   logic        iEXT_ACK;
   logic [31:0] oPENDING;

   int vectors;
   int miscompares;

   ext_irq_requester #(.IRQ_COUNT(32)) dut (
      .iCLOCK      (iCLOCK),
      .iRESET_SYNC (iRESET_SYNC),
      .iIRQ        (iIRQ),
      .iCFG_VALID  (iCFG_VALID),
      .iCFG_ENTRY  (iCFG_ENTRY),
      .iCFG_ENABLE (iCFG_ENABLE),
      .iCFG_EDGE   (iCFG_EDGE),
      .oEXT_ACTIVE (oEXT_ACTIVE),
      .oEXT_NUM    (oEXT_NUM),
      .iEXT_ACK    (iEXT_ACK),
      .oPENDING    (oPENDING)
   );

   initial begin
      iCLOCK = 1'b0;
      forever #5 iCLOCK = ~iCLOCK;
   end

   task automatic tick();
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [4:0] entry, input logic en, input logic edg);
      iCFG_VALID  = 1'b1;
      iCFG_ENTRY  = entry;
      iCFG_ENABLE = en;
      iCFG_EDGE   = edg;
      tick();
      iCFG_VALID  = 1'b0;
   endtask

   task automatic do_reset();
      iRESET_SYNC = 1'b1;
      tick();
      iRESET_SYNC = 1'b0;
   endtask

   task automatic ack_pulse();
      iEXT_ACK = 1'b1;
      tick();
      iEXT_ACK = 1'b0;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      iRESET_SYNC = 1'b1;
      iIRQ = '0;
      iCFG_VALID = 1'b0;
      iCFG_ENTRY = '0;
      iCFG_ENABLE = 1'b0;
      iCFG_EDGE = 1'b0;
      iEXT_ACK = 1'b0;
      tick();
      tick();
      chk("rst_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      chk("rst_num", {26'd0, oEXT_NUM}, 32'd0);
      chk("rst_pending", oPENDING, 32'd0);
      iRESET_SYNC = 1'b0;

      // Sources disabled after reset
      iIRQ = 32'hFFFF_FFFF;
      repeat (3) tick();
      chk("dis_pending", oPENDING, 32'd0);
      chk("dis_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      iIRQ = '0;
      tick();

      // ACK while idle is ignored
      iEXT_ACK = 1'b1;
      repeat (10) tick();
      chk("idle_ack_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      chk("idle_ack_num", {26'd0, oEXT_NUM}, 32'd0);
      iEXT_ACK = 1'b0;

      // Edge source 5
      cfg(5'd5, 1'b1, 1'b1);
      iIRQ = 32'h0000_0020;
      tick();
      chk("e5_pending_set", oPENDING, 32'h0000_0020);
      chk("e5_not_yet_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      iIRQ = '0;
      tick();
      chk("e5_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      chk("e5_num", {26'd0, oEXT_NUM}, 32'd5);
      tick();
      tick();
      chk("e5_hold_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      chk("e5_hold_num", {26'd0, oEXT_NUM}, 32'd5);
      ack_pulse();
      chk("e5_ack_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      chk("e5_ack_pending", oPENDING, 32'd0);
      tick();
      tick();
      chk("e5_no_rereq", {31'd0, oEXT_ACTIVE}, 32'd0);

      // Level sources 0, 3, 31 round robin
      do_reset();
      cfg(5'd0, 1'b1, 1'b0);
      cfg(5'd3, 1'b1, 1'b0);
      cfg(5'd31, 1'b1, 1'b0);
      iIRQ = 32'h8000_0009;
      tick();
      chk("lv_pending", oPENDING, 32'h8000_0009);
      tick();
      chk("lv_g0_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      chk("lv_g0_num", {26'd0, oEXT_NUM}, 32'd0);
      ack_pulse();
      chk("lv_gap_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      tick();
      chk("lv_idle_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      tick();
      chk("lv_g3_num", {26'd0, oEXT_NUM}, 32'd3);
      chk("lv_g3_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      ack_pulse();
      tick();
      tick();
      chk("lv_g31_num", {26'd0, oEXT_NUM}, 32'd31);
      chk("lv_g31_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      ack_pulse();
      tick();
      tick();
      chk("lv_g0b_num", {26'd0, oEXT_NUM}, 32'd0);
      chk("lv_g0b_pending", oPENDING, 32'h8000_0009);
      ack_pulse();
      iIRQ = '0;
      tick();
      tick();
      chk("lv_drained_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      chk("lv_drained_pending", oPENDING, 32'd0);

      // Edge on source 7 coincident with ACK
      do_reset();
      cfg(5'd7, 1'b1, 1'b1);
      iIRQ = 32'h0000_0080;
      tick();
      iIRQ = '0;
      tick();
      chk("e7_num", {26'd0, oEXT_NUM}, 32'd7);
      iIRQ = 32'h0000_0080;
      iEXT_ACK = 1'b1;
      tick();
      iIRQ = '0;
      iEXT_ACK = 1'b0;
      chk("e7_set_wins", oPENDING, 32'h0000_0080);
      chk("e7_gap_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      tick();
      chk("e7_idle_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      tick();
      chk("e7_rereq_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      chk("e7_rereq_num", {26'd0, oEXT_NUM}, 32'd7);
      ack_pulse();
      chk("e7_cleared", oPENDING, 32'd0);

      // Disable source 9 while it is held in REQ
      cfg(5'd9, 1'b1, 1'b1);
      iIRQ = 32'h0000_0200;
      tick();
      iIRQ = '0;
      tick();
      chk("d9_num", {26'd0, oEXT_NUM}, 32'd9);
      cfg(5'd9, 1'b0, 1'b0);
      chk("d9_hold_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      chk("d9_hold_pending", oPENDING, 32'h0000_0200);
      tick();
      chk("d9_hold2_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      chk("d9_hold2_num", {26'd0, oEXT_NUM}, 32'd9);
      ack_pulse();
      chk("d9_ack_pending", oPENDING, 32'd0);
      repeat (3) tick();
      chk("d9_no_rereq", {31'd0, oEXT_ACTIVE}, 32'd0);

      // Reset while in REQ
      do_reset();
      cfg(5'd5, 1'b1, 1'b1);
      iIRQ = 32'h0000_0020;
      tick();
      iIRQ = '0;
      tick();
      chk("rq_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      do_reset();
      chk("rq_rst_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      chk("rq_rst_pending", oPENDING, 32'd0);
      chk("rq_rst_num", {26'd0, oEXT_NUM}, 32'd0);
      tick();
      ack_pulse();
      chk("rq_late_ack", {31'd0, oEXT_ACTIVE}, 32'd0);
      iIRQ = 32'hFFFF_FFFF;
      repeat (3) tick();
      chk("rq_ones_active", {31'd0, oEXT_ACTIVE}, 32'd0);
      chk("rq_ones_pending", oPENDING, 32'd0);
      cfg(5'd2, 1'b1, 1'b0);
      chk("rq_cfg_pending", oPENDING, 32'd0);
      tick();
      chk("rq_en_pending", oPENDING, 32'h0000_0004);
      tick();
      chk("rq_en_active", {31'd0, oEXT_ACTIVE}, 32'd1);
      chk("rq_en_num", {26'd0, oEXT_NUM}, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ext_irq_requester.md
EXT_IRQ_REQUESTER -- requirements
Module: ext_irq_requester

Interface
REQ-001 Parameter: IRQ_COUNT, default 32, number of device interrupt sources; fixed at 32 for this revision.
REQ-002 iCLOCK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 iRESET_SYNC  in  1  synchronous, active-high reset; there SHALL be no asynchronous reset.
REQ-004 iIRQ  in  32  device interrupt lines, synchronous to iCLOCK.
REQ-005 iCFG_VALID  in  1  configuration write strobe.
REQ-006 iCFG_ENTRY  in  5  source index written.
REQ-007 iCFG_ENABLE  in  1  source enable value.
REQ-008 iCFG_EDGE  in  1  trigger mode value: 1 = rising edge, 0 = level-high.
REQ-009 oEXT_ACTIVE  out  1  request to the interrupt controller.
REQ-010 oEXT_NUM  out  6  requested source number, {1'b0, index}.
REQ-011 iEXT_ACK  in  1  one-cycle acceptance pulse from the interrupt controller.
REQ-012 oPENDING  out  32  pending-bit status, registered.

Function
REQ-013 Configuration writes SHALL take effect on the next clock edge:
- cfg_en[iCFG_ENTRY] <= iCFG_ENABLE
- cfg_edge[iCFG_ENTRY] <= iCFG_EDGE
REQ-014 Edge detection SHALL use a registered copy of iIRQ (irq_prev):
- edge[i] = iIRQ[i] & ~irq_prev[i]
- irq_prev SHALL reset to 0.
REQ-015 Pending set condition, per source i (only when cfg_en[i] = 1):
- edge mode: pending[i] SHALL set on edge[i].
- level mode: pending[i] SHALL equal iIRQ[i] each cycle.
REQ-016 Clearing cfg_en[i] SHALL clear pending[i] on the same edge, except for the source currently held in REQ (see REQ-021).
REQ-017 FSM states: IDLE, REQ, GAP. Reset state is IDLE.
REQ-018 IDLE:
- If any pending bit is set, select a winner by round-robin (REQ-019).
- Latch the winner's index into the number register and go to REQ.
- oEXT_ACTIVE SHALL rise on the cycle after the pending bit is visible.
REQ-019 Round-robin arbitration:
- The search SHALL start at (last_grant + 1) mod 32 and wrap from 31 to 0.
- last_grant SHALL reset to 31, so source 0 has first priority after reset.
- last_grant SHALL update only on acceptance (REQ-020).
REQ-020 REQ:
- oEXT_ACTIVE = 1, and oEXT_NUM SHALL be held stable until acceptance.
- On iEXT_ACK = 1: go to GAP and set last_grant to the granted index.
- For an edge-mode source, clear pending[granted] on the same edge.
REQ-021 A request in REQ SHALL never be retracted:
- Disabling or reconfiguring the granted source SHALL NOT drop oEXT_ACTIVE before iEXT_ACK.
- The disable SHALL apply after acceptance.
REQ-022 GAP SHALL last exactly one cycle with oEXT_ACTIVE = 0, then the FSM SHALL go to IDLE. This guarantees the controller sees ACTIVE low before any new request.
REQ-023 A new edge on the granted source in the same cycle as iEXT_ACK SHALL leave pending set (set wins over clear).
REQ-024 A level source that is still high after acceptance SHALL re-request; it competes again by round-robin in IDLE.
REQ-025 iEXT_ACK outside REQ SHALL be ignored.
REQ-026 Minimum request-to-request spacing SHALL be 3 cycles: ACK edge -> GAP -> IDLE -> REQ.
REQ-027 oEXT_ACTIVE, oEXT_NUM and oPENDING SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-028 When iRESET_SYNC = 1 at a clock edge, all of the following SHALL take effect on that edge, regardless of state:
- FSM = IDLE
- oEXT_ACTIVE = 0
- oEXT_NUM = 0
- pending = 0
- cfg_en = 0
- cfg_edge = 0
- irq_prev = 0
- last_grant = 31
REQ-029 A reset asserted while in REQ SHALL drop oEXT_ACTIVE on the next edge with no acknowledgement required. A later iEXT_ACK SHALL be ignored.
REQ-030 Sources SHALL be disabled after reset; no request SHALL be raised until enabled by a configuration write.

Verification
REQ-031 Enable source 5 in edge mode; pulse iIRQ[5] for 1 cycle -> the next cycle shows oEXT_ACTIVE = 1 and oEXT_NUM = 6'h05, held until iEXT_ACK; the cycle after ACK shows ACTIVE = 0 and oPENDING[5] = 0.
REQ-032 Enable sources 0, 3 and 31 in level mode with all held high -> successive grants are 0, 3, 31, 0, each spaced 3 cycles after the ACK.
REQ-033 Source 7 in edge mode, with a new rising edge in the same cycle as iEXT_ACK for source 7 -> oPENDING[7] stays 1 and a second request for 7 follows after GAP.
REQ-034 Source 9 in REQ, then a config write disabling source 9 -> oEXT_ACTIVE stays 1 with NUM 6'h09 until ACK; afterwards pending[9] = 0 and no re-request.
REQ-035 Assert iRESET_SYNC in REQ -> ACTIVE = 0, oPENDING = 0 and NUM = 0 next cycle; an iEXT_ACK 2 cycles later has no effect; iIRQ = all ones produces no request until re-enabled.
REQ-036 Hold iEXT_ACK high for 10 cycles while IDLE with nothing pending -> ACTIVE stays 0 and the state remains IDLE.
